// File: rtl/threshold_config_ctrl.sv
// Front-panel controller for the HSV colour-reduction thresholds.
// Three buttons (next / up / down) edit a 3-bit shadow level per channel,
// with hold-to-repeat stepping. Shadow levels are committed to the active
// 8-bit masks only on frame_start, so the pixel pipeline never sees a
// mask change in the middle of a frame.
module threshold_config_ctrl #(
  parameter logic [23:0] REPEAT_DELAY  = 24'd13_500_000,
  parameter logic [23:0] REPEAT_RATE   = 24'd3_375_000,
  parameter logic [2:0]  H_RESET_LEVEL = 3'd2,
  parameter logic [2:0]  S_RESET_LEVEL = 3'd1,
  parameter logic [2:0]  V_RESET_LEVEL = 3'd1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       frame_start,
  output logic [7:0] h_threshold,
  output logic [7:0] s_threshold,
  output logic [7:0] v_threshold,
  output logic [1:0] channel,
  output logic [2:0] level,
  output logic       pending
);

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_HOLD_DELAY  = 2'd1,
    ST_HOLD_REPEAT = 2'd2
  } state_t;

  // Level L keeps the top L+1 bits of the mask set.
  function automatic logic [7:0] mask_f(input logic [2:0] lvl);
    mask_f = 8'hFF << (3'd7 - lvl);
  endfunction

  // Saturating +1 / -1 step of a 3-bit level.
  function automatic logic [2:0] step_f(input logic [2:0] lvl, input logic inc, input logic dec);
    if (inc && (lvl != 3'd7)) begin
      step_f = lvl + 3'd1;
    end else if (dec && (lvl != 3'd0)) begin
      step_f = lvl - 3'd1;
    end else begin
      step_f = lvl;
    end
  endfunction

  // Edge detection state; the arm bits block a button that was already held
  // when reset released until it has been seen released once.
  logic next_prev_q, up_prev_q, down_prev_q;
  logic next_arm_q, up_arm_q, down_arm_q;

  // Step FSM state
  state_t      state_q;
  logic [23:0] cnt_q;
  logic        dir_dn_q;

  // Shadow / committed levels and registered outputs
  logic [2:0] sh_h_q, sh_s_q, sh_v_q, sh_h_d, sh_s_d, sh_v_d;
  logic [2:0] cm_h_q, cm_s_q, cm_v_q, cm_h_d, cm_s_d, cm_v_d;
  logic [7:0] h_thr_q, s_thr_q, v_thr_q, h_thr_d, s_thr_d, v_thr_d;
  logic [1:0] ch_q, ch_d;
  logic [2:0] level_q, level_d;
  logic       pending_q, pending_d;

  // Combinational decision signals
  logic        next_rise_s, up_rise_s, down_rise_s;
  logic        active_s, opposite_s;
  logic [23:0] term_s;
  logic        inc_s, dec_s, start_s, abort_s, fire_s;

  assign next_rise_s = btn_next & ~next_prev_q & next_arm_q;
  assign up_rise_s   = btn_up   & ~up_prev_q   & up_arm_q;
  assign down_rise_s = btn_down & ~down_prev_q & down_arm_q;
  assign active_s    = dir_dn_q ? btn_down : btn_up;
  assign opposite_s  = dir_dn_q ? btn_up   : btn_down;

  // Button history: previous sample and release-seen arm bit per button.
  always_ff @(posedge clk) begin
    if (reset) begin
      next_prev_q <= 1'b0;
      up_prev_q   <= 1'b0;
      down_prev_q <= 1'b0;
      next_arm_q  <= 1'b0;
      up_arm_q    <= 1'b0;
      down_arm_q  <= 1'b0;
    end else begin
      next_prev_q <= btn_next;
      up_prev_q   <= btn_up;
      down_prev_q <= btn_down;
      next_arm_q  <= next_arm_q | ~btn_next;
      up_arm_q    <= up_arm_q   | ~btn_up;
      down_arm_q  <= down_arm_q | ~btn_down;
    end
  end

  // Step decisions for the current cycle, derived from FSM state and buttons.
  always_comb begin
    inc_s   = 1'b0;
    dec_s   = 1'b0;
    start_s = 1'b0;
    abort_s = 1'b0;
    fire_s  = 1'b0;
    term_s  = (state_q == ST_HOLD_DELAY) ? (REPEAT_DELAY - 24'd1) : (REPEAT_RATE - 24'd1);
    case (state_q)
      ST_IDLE: begin
        if (up_rise_s && !btn_down) begin
          inc_s   = 1'b1;
          start_s = 1'b1;
        end else if (down_rise_s && !btn_up) begin
          dec_s   = 1'b1;
          start_s = 1'b1;
        end else begin
          start_s = 1'b0;
        end
      end
      ST_HOLD_DELAY, ST_HOLD_REPEAT: begin
        if (!active_s || opposite_s) begin
          abort_s = 1'b1;
        end else if (cnt_q == term_s) begin
          fire_s = 1'b1;
          inc_s  = ~dir_dn_q;
          dec_s  = dir_dn_q;
        end else begin
          fire_s = 1'b0;
        end
      end
      default: abort_s = 1'b1;
    endcase
  end

  // Step FSM: tracks which button is held and counts toward the next repeat.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 24'd0;
      dir_dn_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q <= 24'd0;
          if (start_s) begin
            state_q  <= ST_HOLD_DELAY;
            dir_dn_q <= dec_s;
          end
        end
        ST_HOLD_DELAY, ST_HOLD_REPEAT: begin
          if (abort_s) begin
            state_q <= ST_IDLE;
            cnt_q   <= 24'd0;
          end else if (fire_s) begin
            state_q <= ST_HOLD_REPEAT;
            cnt_q   <= 24'd0;
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= 24'd0;
        end
      endcase
    end
  end

  // Next-state of shadow levels, channel, committed levels, masks and status.
  always_comb begin
    sh_h_d = sh_h_q;
    sh_s_d = sh_s_q;
    sh_v_d = sh_v_q;
    case (ch_q)
      2'd0:    sh_h_d = step_f(sh_h_q, inc_s, dec_s);
      2'd1:    sh_s_d = step_f(sh_s_q, inc_s, dec_s);
      2'd2:    sh_v_d = step_f(sh_v_q, inc_s, dec_s);
      default: sh_h_d = sh_h_q;
    endcase

    if (next_rise_s) begin
      ch_d = (ch_q == 2'd2) ? 2'd0 : (ch_q + 2'd1);
    end else begin
      ch_d = ch_q;
    end

    // Commit takes the shadow values from before this edge.
    if (frame_start) begin
      cm_h_d  = sh_h_q;
      cm_s_d  = sh_s_q;
      cm_v_d  = sh_v_q;
      h_thr_d = mask_f(sh_h_q);
      s_thr_d = mask_f(sh_s_q);
      v_thr_d = mask_f(sh_v_q);
    end else begin
      cm_h_d  = cm_h_q;
      cm_s_d  = cm_s_q;
      cm_v_d  = cm_v_q;
      h_thr_d = h_thr_q;
      s_thr_d = s_thr_q;
      v_thr_d = v_thr_q;
    end

    pending_d = (sh_h_d != cm_h_d) | (sh_s_d != cm_s_d) | (sh_v_d != cm_v_d);

    case (ch_d)
      2'd0:    level_d = sh_h_d;
      2'd1:    level_d = sh_s_d;
      default: level_d = sh_v_d;
    endcase
  end

  // Level, channel, commit and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_h_q    <= H_RESET_LEVEL;
      sh_s_q    <= S_RESET_LEVEL;
      sh_v_q    <= V_RESET_LEVEL;
      cm_h_q    <= H_RESET_LEVEL;
      cm_s_q    <= S_RESET_LEVEL;
      cm_v_q    <= V_RESET_LEVEL;
      h_thr_q   <= mask_f(H_RESET_LEVEL);
      s_thr_q   <= mask_f(S_RESET_LEVEL);
      v_thr_q   <= mask_f(V_RESET_LEVEL);
      ch_q      <= 2'd0;
      level_q   <= H_RESET_LEVEL;
      pending_q <= 1'b0;
    end else begin
      sh_h_q    <= sh_h_d;
      sh_s_q    <= sh_s_d;
      sh_v_q    <= sh_v_d;
      cm_h_q    <= cm_h_d;
      cm_s_q    <= cm_s_d;
      cm_v_q    <= cm_v_d;
      h_thr_q   <= h_thr_d;
      s_thr_q   <= s_thr_d;
      v_thr_q   <= v_thr_d;
      ch_q      <= ch_d;
      level_q   <= level_d;
      pending_q <= pending_d;
    end
  end

  assign h_threshold = h_thr_q;
  assign s_threshold = s_thr_q;
  assign v_threshold = v_thr_q;
  assign channel     = ch_q;
  assign level       = level_q;
  assign pending     = pending_q;

endmodule

// File: tb/tb_threshold_config_ctrl.sv
// Self-checking bench for threshold_config_ctrl with short repeat timing.
module tb_threshold_config_ctrl;

  localparam int D = 8;
  localparam int R = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_next = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       frame_start = 1'b0;
  logic [7:0] h_threshold, s_threshold, v_threshold;
  logic [1:0] channel;
  logic [2:0] level;
  logic       pending;

  int checks = 0;
  int fails  = 0;

  threshold_config_ctrl #(
    .REPEAT_DELAY (24'd8),
    .REPEAT_RATE  (24'd4),
    .H_RESET_LEVEL(3'd2),
    .S_RESET_LEVEL(3'd1),
    .V_RESET_LEVEL(3'd1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_next   (btn_next),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .frame_start(frame_start),
    .h_threshold(h_threshold),
    .s_threshold(s_threshold),
    .v_threshold(v_threshold),
    .channel    (channel),
    .level      (level),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int sh[3];
  int cm[3];
  int ch;
  int pu, pd, pn;   // previous button levels; 1 after reset means "must release first"
  int hold;         // 0 none, 1 up held, 2 down held
  int age;          // cycles since the press that started the hold

  function automatic logic [7:0] m_mask(input int l);
    logic [7:0] all_ones;
    all_ones = 8'hFF;
    return all_ones ^ (all_ones >> (l + 1));
  endfunction

  function automatic logic [29:0] exp_vec();
    logic pend;
    pend = (sh[0] != cm[0]) || (sh[1] != cm[1]) || (sh[2] != cm[2]);
    return {m_mask(cm[0]), m_mask(cm[1]), m_mask(cm[2]), 2'(ch), 3'(sh[ch]), pend};
  endfunction

  function automatic logic [29:0] got_vec();
    return {h_threshold, s_threshold, v_threshold, channel, level, pending};
  endfunction

  task automatic m_reset();
    sh[0] = 2; sh[1] = 1; sh[2] = 1;
    cm = sh;
    ch = 0;
    pu = 1; pd = 1; pn = 1;
    hold = 0; age = 0;
  endtask

  task automatic m_cycle(input int u, input int d, input int n, input int f);
    int st, act, opp, v;
    st = 0;
    if (hold != 0) begin
      act = (hold == 1) ? u : d;
      opp = (hold == 1) ? d : u;
      if (!act || opp) hold = 0;
      else begin
        age++;
        if (age >= D && ((age - D) % R) == 0) st = (hold == 1) ? 1 : -1;
      end
    end else if (u && !pu && !d) begin
      st = 1; hold = 1; age = 0;
    end else if (d && !pd && !u) begin
      st = -1; hold = 2; age = 0;
    end
    if (f) cm = sh;
    v = sh[ch] + st;
    if (v > 7) v = 7;
    if (v < 0) v = 0;
    sh[ch] = v;
    if (n && !pn) ch = (ch + 1) % 3;
    pu = u; pd = d; pn = n;
  endtask

  // One clock: drive inputs, advance the model, sample after the edge.
  task automatic tick(input int u, input int d, input int n, input int f);
    btn_up = 1'(u); btn_down = 1'(d); btn_next = 1'(n); frame_start = 1'(f);
    m_cycle(u, d, n, f);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int u, input int d);
    reset = 1'b1;
    btn_up = 1'(u); btn_down = 1'(d); btn_next = 1'b0; frame_start = 1'b0;
    m_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset(0, 0);
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 0, 0);
      checks++;
      if (got_vec() !== {8'hE0, 8'hC0, 8'hC0, 2'd0, 3'd2, 1'b0}) begin
        fails++;
        $display("FAIL reset_idle cycle %0d: got %h required %h", i, got_vec(),
                 {8'hE0, 8'hC0, 8'hC0, 2'd0, 3'd2, 1'b0});
      end
    end
  endtask

  task automatic test_single_up();
    tick(1, 0, 0, 0);
    checks++;
    if ({h_threshold, level, pending} !== {8'hE0, 3'd3, 1'b1}) begin
      fails++;
      $display("FAIL single_up_press: got h=%h lvl=%0d pend=%b required h=e0 lvl=3 pend=1",
               h_threshold, level, pending);
    end
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    checks++;
    if ({h_threshold, level, pending} !== {8'hF0, 3'd3, 1'b0}) begin
      fails++;
      $display("FAIL single_up_commit: got h=%h lvl=%0d pend=%b required h=f0 lvl=3 pend=0",
               h_threshold, level, pending);
    end
  endtask

  task automatic test_next_down();
    do_reset(0, 0);
    tick(0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick(0, 0, 1, 0);
      tick(0, 0, 0, 0);
    end
    checks++;
    if (channel !== 2'd2) begin
      fails++;
      $display("FAIL next_twice: got channel %0d required 2", channel);
    end
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 0, 0);
      tick(0, 0, 0, 0);
      checks++;
      if (level !== 3'd0 || got_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL down_saturate press %0d: got %h required %h (level 0)", i, got_vec(), exp_vec());
      end
    end
    tick(0, 0, 0, 1);
    checks++;
    if ({v_threshold, pending} !== {8'h80, 1'b0}) begin
      fails++;
      $display("FAIL v_commit: got v=%h pend=%b required v=80 pend=0", v_threshold, pending);
    end
  endtask

  task automatic test_hold_repeat();
    int steps;
    int lvl;
    do_reset(0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);
    for (int k = 0; k < 30; k++) begin
      tick(1, 0, 0, 0);
      steps = 0;
      if (k >= 0) steps++;
      if (k >= 8) steps += 1 + (k - 8) / 4;
      lvl = 1 + steps;
      if (lvl > 7) lvl = 7;
      checks++;
      if (level !== 3'(lvl) || got_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL hold_repeat cycle %0d: got %h lvl=%0d required %h lvl=%0d",
                 k, got_vec(), level, exp_vec(), lvl);
      end
    end
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    checks++;
    if ({s_threshold, pending} !== {8'hFF, 1'b0}) begin
      fails++;
      $display("FAIL hold_commit: got s=%h pend=%b required s=ff pend=0", s_threshold, pending);
    end
  endtask

  task automatic test_frame_coincide();
    do_reset(0, 0);
    tick(0, 0, 0, 0);
    tick(1, 0, 0, 1);
    checks++;
    if ({h_threshold, level, pending} !== {8'hE0, 3'd3, 1'b1}) begin
      fails++;
      $display("FAIL coincide_step: got h=%h lvl=%0d pend=%b required h=e0 lvl=3 pend=1",
               h_threshold, level, pending);
    end
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    checks++;
    if ({h_threshold, pending} !== {8'hF0, 1'b0}) begin
      fails++;
      $display("FAIL coincide_next_commit: got h=%h pend=%b required h=f0 pend=0", h_threshold, pending);
    end
  endtask

  task automatic test_both_and_reset();
    do_reset(0, 0);
    tick(0, 0, 0, 0);
    tick(1, 1, 0, 0);
    checks++;
    if (level !== 3'd2) begin
      fails++;
      $display("FAIL both_press: got level %0d required 2", level);
    end
    tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0);
    // Opposite button joins: hold aborts, nothing further may step.
    for (int i = 0; i < 12; i++) tick(1, 1, 0, 0);
    for (int i = 0; i < 12; i++) tick(1, 0, 0, 0);
    checks++;
    if (level !== 3'd3 || got_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL hold_abort: got %h lvl=%0d required %h lvl=3", got_vec(), level, exp_vec());
    end
    // Reset in the middle of a fresh hold, button kept down through and after.
    tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(1, 0, 0, 0);
    do_reset(1, 0);
    checks++;
    if (got_vec() !== {8'hE0, 8'hC0, 8'hC0, 2'd0, 3'd2, 1'b0}) begin
      fails++;
      $display("FAIL reset_mid_hold: got %h required %h", got_vec(), {8'hE0, 8'hC0, 8'hC0, 2'd0, 3'd2, 1'b0});
    end
    for (int i = 0; i < 14; i++) tick(1, 0, 0, 0);
    checks++;
    if (level !== 3'd2 || pending !== 1'b0) begin
      fails++;
      $display("FAIL held_after_reset: got lvl=%0d pend=%b required lvl=2 pend=0", level, pending);
    end
    tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    checks++;
    if (level !== 3'd3) begin
      fails++;
      $display("FAIL repress_after_reset: got level %0d required 3", level);
    end
    tick(0, 0, 0, 0);
  endtask

  task automatic test_random();
    int u, d, n, f, mism;
    u = 0; d = 0; n = 0; mism = 0;
    do_reset(0, 0);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(u, d);
      end else begin
        if ($urandom_range(0, 11) == 0) u = 1 - u;
        if ($urandom_range(0, 13) == 0) d = 1 - d;
        n = ($urandom_range(0, 19) == 0) ? 1 - n : n;
        f = ($urandom_range(0, 9) == 0) ? 1 : 0;
        tick(u, d, n, f);
      end
      checks++;
      if (got_vec() !== exp_vec()) begin
        fails++;
        mism++;
        if (mism <= 10)
          $display("FAIL random cycle %0d: got %h required %h", i, got_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_up();
    test_next_down();
    test_hold_repeat();
    test_frame_coincide();
    test_both_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
